// File: rtl/pio_pkg.sv
// Shared PIO definitions: action codes, loader FSM states, command payload and length clamp.
package pio_pkg;

  localparam int unsigned ACT_W   = 6;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned MIDX_W  = 2;
  localparam int unsigned DIN_W   = 32;
  localparam int unsigned LEN_W   = 6;
  localparam int unsigned MAX_LEN = 32;

  typedef enum logic [ACT_W-1:0] {
    ACT_NONE  = 6'd0,
    ACT_INSTR = 6'd1,
    ACT_PEND  = 6'd2,
    ACT_PULL  = 6'd3,
    ACT_PUSH  = 6'd4,
    ACT_GRPS  = 6'd5,
    ACT_EN    = 6'd6,
    ACT_DIV   = 6'd7,
    ACT_SIDES = 6'd8,
    ACT_IMM   = 6'd9,
    ACT_SHIFT = 6'd10
  } action_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PEND,
    DIV,
    GRPS,
    EN,
    FIN
  } state_e;

  typedef struct packed {
    action_e             action;
    logic [IDX_W-1:0]    index;
    logic [MIDX_W-1:0]   mindex;
    logic [DIN_W-1:0]    din;
  } cmd_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/pio_loader_prog_ram.sv
// Program store: synchronous write, asynchronous read, never cleared by reset.
module pio_loader_prog_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned W     = 16,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pio_loader.sv
// Streams a stored PIO program plus PEND/DIV/GRPS/EN config commands to one state machine.
// Optional macro PIO_LOADER_ABORT_EN adds an abort input that cuts a sequence short.
module pio_loader
  import pio_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 32,
  parameter int unsigned INSTR_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_we,
  input  logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic [5:0]  plen,
  input  logic [23:0] cfg_div,
  input  logic [31:0] cfg_grps,
  input  logic [31:0] cfg_exec,
  input  logic [3:0]  cfg_en,
  input  logic [1:0]  msel,
  input  logic        start,
`ifdef PIO_LOADER_ABORT_EN
  input  logic        abort,
`endif
  output logic [5:0]  action,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic [31:0] din,
  output logic        busy,
  output logic        done
);

  state_e             state_q, nxt_state;
  logic [IDX_W-1:0]   idx_q, nxt_idx;
  logic [LEN_W-1:0]   len_q;
  logic [23:0]        div_q, src_div;
  logic [31:0]        grps_q, src_grps;
  logic [31:0]        exec_q, src_exec;
  logic [3:0]         en_q, src_en;
  logic [1:0]         msel_q, src_msel;
  logic [INSTR_W-1:0] rd_data;
  logic               last;
  logic               launch;
  cmd_t               cmd_q, nxt_cmd;
  logic               busy_q, done_q;

  // Store is write-protected for the whole sequence; reads follow the next index.
  pio_loader_prog_ram #(
    .DEPTH (PROG_DEPTH),
    .W     (INSTR_W),
    .AW    (IDX_W)
  ) u_prog_ram (
    .clk   (clk),
    .we    (prog_we && (state_q == IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (nxt_idx),
    .rdata (rd_data)
  );

  assign launch = (state_q == IDLE) && start;
  assign last   = ({1'b0, idx_q} == LEN_W'(len_q - LEN_W'(1)));

  // While idle the first command must come straight from the inputs, not the latches.
  assign src_div  = (state_q == IDLE) ? cfg_div  : div_q;
  assign src_grps = (state_q == IDLE) ? cfg_grps : grps_q;
  assign src_exec = (state_q == IDLE) ? cfg_exec : exec_q;
  assign src_en   = (state_q == IDLE) ? cfg_en   : en_q;
  assign src_msel = (state_q == IDLE) ? msel     : msel_q;

  // Next-state logic: state_q names the command currently on the outputs.
  always_comb begin
    nxt_state = state_q;
    nxt_idx   = idx_q;
    case (state_q)
      IDLE: begin
        nxt_idx = '0;
        if (start) nxt_state = (clamp_len(plen) == '0) ? PEND : LOAD;
      end
      LOAD: begin
        if (last) begin
          nxt_state = PEND;
          nxt_idx   = '0;
        end else begin
          nxt_idx = IDX_W'(idx_q + IDX_W'(1));
        end
      end
      PEND:    nxt_state = DIV;
      DIV:     nxt_state = GRPS;
      GRPS:    nxt_state = EN;
      EN:      nxt_state = FIN;
      FIN:     nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
`ifdef PIO_LOADER_ABORT_EN
    if (abort && (state_q != IDLE) && (state_q != FIN)) begin
      nxt_state = FIN;
      nxt_idx   = '0;
    end
`endif
  end

  // Command that becomes visible after the next edge.
  always_comb begin
    nxt_cmd = '0;
    if (nxt_state != IDLE) nxt_cmd.mindex = src_msel;
    case (nxt_state)
      LOAD: begin
        nxt_cmd.action = ACT_INSTR;
        nxt_cmd.index  = nxt_idx;
        nxt_cmd.din    = DIN_W'(rd_data);
      end
      PEND: begin
        nxt_cmd.action = ACT_PEND;
        nxt_cmd.din    = src_exec;
      end
      DIV: begin
        nxt_cmd.action = ACT_DIV;
        nxt_cmd.din    = DIN_W'(src_div);
      end
      GRPS: begin
        nxt_cmd.action = ACT_GRPS;
        nxt_cmd.din    = src_grps;
      end
      EN: begin
        nxt_cmd.action = ACT_EN;
        nxt_cmd.din    = DIN_W'(src_en);
      end
      default: nxt_cmd.action = ACT_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      div_q   <= '0;
      grps_q  <= '0;
      exec_q  <= '0;
      en_q    <= '0;
      msel_q  <= '0;
      cmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= nxt_state;
      idx_q   <= nxt_idx;
      cmd_q   <= nxt_cmd;
      busy_q  <= (nxt_state != IDLE);
      done_q  <= (nxt_state == FIN);
      if (launch) begin
        len_q  <= clamp_len(plen);
        div_q  <= cfg_div;
        grps_q <= cfg_grps;
        exec_q <= cfg_exec;
        en_q   <= cfg_en;
        msel_q <= msel;
      end
    end
  end

  assign action = cmd_q.action;
  assign index  = cmd_q.index;
  assign mindex = cmd_q.mindex;
  assign din    = cmd_q.din;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_pio_loader.sv
// Directed bench for pio_loader: table of load sequences plus busy, reset and abort corners.
module tb_pio_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic [5:0]  plen;
  logic [23:0] cfg_div;
  logic [31:0] cfg_grps;
  logic [31:0] cfg_exec;
  logic [3:0]  cfg_en;
  logic [1:0]  msel;
  logic        start;
`ifdef PIO_LOADER_ABORT_EN
  logic        abort;
`endif
  logic [5:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic        busy;
  logic        done;

  typedef struct {
    logic [5:0]  plen;
    logic [23:0] div;
    logic [31:0] grps;
    logic [31:0] exec;
    logic [3:0]  en;
    logic [1:0]  msel;
    int          n_instr;
    int          done_cyc;
  } vec_t;

  vec_t        tbl [5];
  logic [15:0] prog_mem [32];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  pio_loader dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .plen      (plen),
    .cfg_div   (cfg_div),
    .cfg_grps  (cfg_grps),
    .cfg_exec  (cfg_exec),
    .cfg_en    (cfg_en),
    .msel      (msel),
    .start     (start),
`ifdef PIO_LOADER_ABORT_EN
    .abort     (abort),
`endif
    .action    (action),
    .index     (index),
    .mindex    (mindex),
    .din       (din),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " action"}, 32'(action), 32'd0);
    chk({tag, " index"},  32'(index),  32'd0);
    chk({tag, " mindex"}, 32'(mindex), 32'd0);
    chk({tag, " din"},    din,         32'd0);
    chk({tag, " busy"},   32'(busy),   32'd0);
    chk({tag, " done"},   32'(done),   32'd0);
  endtask

  task automatic prog_write(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    prog_mem[a] = d;
  endtask

  // Expected command for cycle k after start (k = 1 is the first command).
  task automatic check_cycle(input vec_t v, input int k, input string tag);
    logic [31:0] ea, ei, ed;
    int n;
    n  = v.n_instr;
    ea = 32'd0; ei = 32'd0; ed = 32'd0;
    if (k <= n) begin
      ea = 32'd1; ei = 32'(k - 1); ed = {16'h0, prog_mem[k-1]};
    end else begin
      case (k - n)
        1: begin ea = 32'd2; ed = v.exec; end
        2: begin ea = 32'd7; ed = {8'h0, v.div}; end
        3: begin ea = 32'd5; ed = v.grps; end
        4: begin ea = 32'd6; ed = {28'h0, v.en}; end
        default: begin ea = 32'd0; ed = 32'd0; end
      endcase
    end
    chk($sformatf("%s c%0d action", tag, k), 32'(action), ea);
    chk($sformatf("%s c%0d index", tag, k),  32'(index),  ei);
    chk($sformatf("%s c%0d din", tag, k),    din,         ed);
    chk($sformatf("%s c%0d mindex", tag, k), 32'(mindex), 32'(v.msel));
    chk($sformatf("%s c%0d busy", tag, k),   32'(busy),   32'd1);
    chk($sformatf("%s c%0d done", tag, k),   32'(done),   32'(k == v.done_cyc));
  endtask

  task automatic launch(input vec_t v);
    @(negedge clk);
    plen = v.plen; cfg_div = v.div; cfg_grps = v.grps; cfg_exec = v.exec;
    cfg_en = v.en; msel = v.msel; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs so any late sampling shows up.
    plen = 6'd5; cfg_div = ~v.div; cfg_grps = ~v.grps; cfg_exec = ~v.exec;
    cfg_en = ~v.en; msel = ~v.msel;
  endtask

  // inj > 0 pokes start and a program write during cycle inj.
  task automatic run_seq(input vec_t v, input int inj, input string tag);
    launch(v);
    for (int k = 1; k <= v.done_cyc; k++) begin
      check_cycle(v, k, tag);
      if (k == inj) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = 5'd0; prog_data = 16'hFFFF;
      end
      @(negedge clk);
      start = 1'b0; prog_we = 1'b0;
    end
    chk_idle({tag, " after"});
  endtask

  initial begin
    vec_t va;
    tbl[0] = '{6'd2,  24'h000280, 32'h04000000, 32'h00001000, 4'h1, 2'd0, 2,  7};
    tbl[1] = '{6'd0,  24'h123456, 32'hDEADBEEF, 32'hCAFEF00D, 4'hA, 2'd3, 0,  5};
    tbl[2] = '{6'd40, 24'hABCDEF, 32'h11223344, 32'h55667788, 4'h5, 2'd2, 32, 37};
    tbl[3] = '{6'd32, 24'h00FF00, 32'h80000001, 32'h0000ABCD, 4'hF, 2'd1, 32, 37};
    tbl[4] = '{6'd1,  24'h000001, 32'h00000002, 32'h00000003, 4'h4, 2'd1, 1,  6};

    reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; plen = '0;
    cfg_div = '0; cfg_grps = '0; cfg_exec = '0; cfg_en = '0; msel = '0; start = 1'b0;
`ifdef PIO_LOADER_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    chk_idle("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    prog_write(5'd0, 16'hE081);
    prog_write(5'd1, 16'hE001);
    for (int i = 2; i < 32; i++) prog_write(5'(i), 16'(16'h6000 + i * 16'h0111));

    for (int t = 0; t < 5; t++) run_seq(tbl[t], 0, $sformatf("tbl%0d", t));

    // Restart and store write during LOAD must both be ignored.
    run_seq(tbl[0], 1, "busy");
    run_seq(tbl[0], 0, "busy_after");

    // Reset during DIV abandons the sequence without done.
    launch(tbl[0]);
    for (int k = 1; k <= 4; k++) begin
      check_cycle(tbl[0], k, "rst_mid");
      if (k < 4) @(negedge clk);
    end
    #2 reset = 1'b0;
    #1 chk_idle("rst_async");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rst_nodone c%0d", k), 32'(done), 32'd0);
      chk($sformatf("rst_nobusy c%0d", k), 32'(busy), 32'd0);
    end
    run_seq(tbl[0], 0, "post_rst");

`ifdef PIO_LOADER_ABORT_EN
    va = '{6'd4, 24'h000280, 32'h04000000, 32'h00001000, 4'h1, 2'd2, 4, 9};
    launch(va);
    check_cycle(va, 1, "abort");
    @(negedge clk);
    check_cycle(va, 2, "abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort fin action", 32'(action), 32'd0);
    chk("abort fin din",    din,         32'd0);
    chk("abort fin done",   32'(done),   32'd1);
    chk("abort fin busy",   32'(busy),   32'd1);
    @(negedge clk);
    chk_idle("abort idle");
    run_seq(tbl[4], 0, "post_abort");
`else
    va = tbl[4];
    run_seq(va, 0, "final");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
